// File: rtl/zoorgi_game_controller.sv
// Game sequencer: coin credit, pattern load, guess-round counting and WIN/LOSE outcome.
// Every output is a flop; events show up one clock after the input cycle.
module zoorgi_game_controller #(
  parameter int COST       = 4,
  parameter int MAX_CREDIT = 28,
  parameter int MAX_ROUNDS = 8
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        CoinInserted,
  input  logic [1:0]  CoinValue,
  input  logic        StartGame,
  input  logic        LoadShapeNow,
  input  logic [1:0]  ShapeLocation,
  input  logic [2:0]  LoadShape,
  input  logic        GradeIt,
  input  logic [3:0]  Znarly,
  output logic [4:0]  Credits,
  output logic [11:0] Pattern,
  output logic        PatternReady,
  output logic [3:0]  RoundNumber,
  output logic        GradeEn,
  output logic        GameWon,
  output logic        GameLost,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PLAY = 3'd2,
    S_WIN  = 3'd3,
    S_LOSE = 3'd4
  } state_e;

  localparam logic [5:0] COST6 = 6'(COST);
  localparam logic [5:0] MAX6  = 6'(MAX_CREDIT);
  localparam logic [3:0] MAXR  = 4'(MAX_ROUNDS);

  state_e      state_q;
  logic [4:0]  credits_q;
  logic [2:0]  slot_q [4];
  logic [3:0]  filled_q;
  logic [3:0]  round_q;
  logic        ready_q, grade_en_q, won_q, lost_q;

  logic [5:0]  coin, charge, sum;
  logic [4:0]  credits_d;
  logic        start_ok, shape_ok;

  always_comb begin
    coin = '0;
    if (CoinInserted) begin
      case (CoinValue)
        2'b01:   coin = 6'd1;
        2'b10:   coin = 6'd3;
        2'b11:   coin = 6'd5;
        default: coin = 6'd0;
      endcase
    end
    // start is qualified on the balance before this cycle's coin
    start_ok  = StartGame && ({1'b0, credits_q} >= COST6) &&
                (state_q == S_IDLE || state_q == S_WIN || state_q == S_LOSE);
    charge    = start_ok ? COST6 : 6'd0;
    sum       = {1'b0, credits_q} + coin - charge;
    credits_d = (sum > MAX6) ? MAX6[4:0] : sum[4:0];
    shape_ok  = (LoadShape != 3'd0) && (LoadShape != 3'd7);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= S_IDLE;
      credits_q  <= '0;
      for (int i = 0; i < 4; i++) slot_q[i] <= '0;
      filled_q   <= '0;
      round_q    <= '0;
      ready_q    <= 1'b0;
      grade_en_q <= 1'b0;
      won_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      credits_q  <= credits_d;
      grade_en_q <= 1'b0;
      case (state_q)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start_ok) begin
            state_q  <= S_LOAD;
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
            filled_q <= '0;
            round_q  <= '0;
            ready_q  <= 1'b0;
            won_q    <= 1'b0;
            lost_q   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (&filled_q) begin
            state_q <= S_PLAY;
            ready_q <= 1'b1;
            round_q <= 4'd1;
          end else if (LoadShapeNow && shape_ok && !filled_q[ShapeLocation]) begin
            slot_q[ShapeLocation]   <= LoadShape;
            filled_q[ShapeLocation] <= 1'b1;
          end
        end
        S_PLAY: begin
          if (GradeIt) begin
            grade_en_q <= 1'b1;
            if (Znarly == 4'd4) begin
              state_q <= S_WIN;
              won_q   <= 1'b1;
            end else if (round_q == MAXR) begin
              state_q <= S_LOSE;
              lost_q  <= 1'b1;
            end else begin
              round_q <= round_q + 4'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Credits      = credits_q;
  assign Pattern      = {slot_q[0], slot_q[1], slot_q[2], slot_q[3]};
  assign PatternReady = ready_q;
  assign RoundNumber  = round_q;
  assign GradeEn      = grade_en_q;
  assign GameWon      = won_q;
  assign GameLost     = lost_q;
  assign State        = state_q;

endmodule
